// File: rtl/acc_rr_arbiter.sv
// Round-robin arbiter sharing one accelerator request/response port among NumReq requesters.
// Optional feature: define ACC_ARB_RSP_REG_EN to add a one-entry pipeline register on the P path.
module acc_rr_arbiter #(
    parameter int NumReq    = 4,
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int IdWidth   = 4,
    parameter int IdxWidth  = $clog2(NumReq)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [AddrWidth-1:0]         slv_q_addr_i      [NumReq],
    input  logic [31:0]                  slv_q_data_op_i   [NumReq],
    input  logic [DataWidth-1:0]         slv_q_data_arga_i [NumReq],
    input  logic [DataWidth-1:0]         slv_q_data_argb_i [NumReq],
    input  logic [DataWidth-1:0]         slv_q_data_argc_i [NumReq],
    input  logic [IdWidth-1:0]           slv_q_id_i        [NumReq],
    input  logic [NumReq-1:0]            slv_q_valid_i,
    output logic [NumReq-1:0]            slv_q_ready_o,
    output logic [DataWidth-1:0]         slv_p_data0_o,
    output logic [DataWidth-1:0]         slv_p_data1_o,
    output logic                         slv_p_dual_writeback_o,
    output logic [4:0]                   slv_p_rd_o,
    output logic                         slv_p_error_o,
    output logic [IdWidth-1:0]           slv_p_id_o,
    output logic [NumReq-1:0]            slv_p_valid_o,
    input  logic [NumReq-1:0]            slv_p_ready_i,
    output logic [AddrWidth-1:0]         mst_q_addr_o,
    output logic [31:0]                  mst_q_data_op_o,
    output logic [DataWidth-1:0]         mst_q_data_arga_o,
    output logic [DataWidth-1:0]         mst_q_data_argb_o,
    output logic [DataWidth-1:0]         mst_q_data_argc_o,
    output logic [IdWidth+IdxWidth-1:0]  mst_q_id_o,
    output logic                         mst_q_valid_o,
    input  logic                         mst_q_ready_i,
    input  logic [DataWidth-1:0]         mst_p_data0_i,
    input  logic [DataWidth-1:0]         mst_p_data1_i,
    input  logic                         mst_p_dual_writeback_i,
    input  logic [4:0]                   mst_p_rd_i,
    input  logic                         mst_p_error_i,
    input  logic [IdWidth+IdxWidth-1:0]  mst_p_id_i,
    input  logic                         mst_p_valid_i,
    output logic                         mst_p_ready_o
);

    localparam int MstIdWidth = IdWidth + IdxWidth;

    logic [IdxWidth-1:0] rr_ptr;
    logic                lock;
    logic [IdxWidth-1:0] lock_idx;
    logic [IdxWidth-1:0] grant;
    logic                found;
    logic                q_valid;

    // Unlocked: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant = lock_idx;
        found = 1'b0;
        if (!lock) begin
            grant = rr_ptr;
            for (int i = 0; i < NumReq; i++) begin
                if (!found &&
                    slv_q_valid_i[(int'(rr_ptr) + i) % NumReq]) begin
                    found = 1'b1;
                    grant = IdxWidth'((int'(rr_ptr) + i) % NumReq);
                end
            end
        end
    end

    assign q_valid       = (|slv_q_valid_i) && !rst_i;
    assign mst_q_valid_o = q_valid;

    always_comb begin
        slv_q_ready_o     = '0;
        mst_q_addr_o      = '0;
        mst_q_data_op_o   = '0;
        mst_q_data_arga_o = '0;
        mst_q_data_argb_o = '0;
        mst_q_data_argc_o = '0;
        mst_q_id_o        = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (int'(grant) == i) begin
                slv_q_ready_o[i]  = mst_q_ready_i && !rst_i;
                mst_q_addr_o      = slv_q_addr_i[i];
                mst_q_data_op_o   = slv_q_data_op_i[i];
                mst_q_data_arga_o = slv_q_data_arga_i[i];
                mst_q_data_argb_o = slv_q_data_argb_i[i];
                mst_q_data_argc_o = slv_q_data_argc_i[i];
                mst_q_id_o        = {grant, slv_q_id_i[i]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
        end else if (q_valid) begin
            if (mst_q_ready_i) begin
                lock   <= 1'b0;
                rr_ptr <= IdxWidth'((int'(grant) + 1) % NumReq);
            end else begin
                lock     <= 1'b1;
                lock_idx <= grant;
            end
        end
    end

    logic [IdxWidth-1:0] p_idx;
    logic                idx_ok;

    assign p_idx  = mst_p_id_i[MstIdWidth-1:IdWidth];
    assign idx_ok = int'(p_idx) < NumReq;

`ifdef ACC_ARB_RSP_REG_EN
    logic                 full;
    logic [IdxWidth-1:0]  r_idx;
    logic [DataWidth-1:0] r_data0;
    logic [DataWidth-1:0] r_data1;
    logic                 r_dw;
    logic [4:0]           r_rd;
    logic                 r_err;
    logic [IdWidth-1:0]   r_id;
    logic                 r_ready;
    logic                 drain;
    logic                 accept;

    always_comb begin
        r_ready = 1'b0;
        for (int i = 0; i < NumReq; i++) begin
            if (int'(r_idx) == i) r_ready = slv_p_ready_i[i];
        end
    end

    assign drain         = full && r_ready;
    assign mst_p_ready_o = !rst_i && (!full || drain);
    assign accept        = mst_p_valid_i && mst_p_ready_o;

    // Out-of-range indices are accepted but never stored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full <= 1'b0;
        end else if (accept && idx_ok) begin
            full <= 1'b1;
        end else if (drain) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && idx_ok) begin
            r_idx   <= p_idx;
            r_data0 <= mst_p_data0_i;
            r_data1 <= mst_p_data1_i;
            r_dw    <= mst_p_dual_writeback_i;
            r_rd    <= mst_p_rd_i;
            r_err   <= mst_p_error_i;
            r_id    <= mst_p_id_i[IdWidth-1:0];
        end
    end

    assign slv_p_data0_o          = r_data0;
    assign slv_p_data1_o          = r_data1;
    assign slv_p_dual_writeback_o = r_dw;
    assign slv_p_rd_o             = r_rd;
    assign slv_p_error_o          = r_err;
    assign slv_p_id_o             = r_id;

    always_comb begin
        slv_p_valid_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (int'(r_idx) == i) slv_p_valid_o[i] = full && !rst_i;
        end
    end
`else
    logic sel_ready;

    always_comb begin
        sel_ready     = 1'b0;
        slv_p_valid_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (int'(p_idx) == i) begin
                sel_ready        = slv_p_ready_i[i];
                slv_p_valid_o[i] = mst_p_valid_i && !rst_i;
            end
        end
    end

    assign mst_p_ready_o          = !rst_i && (idx_ok ? sel_ready : 1'b1);
    assign slv_p_data0_o          = mst_p_data0_i;
    assign slv_p_data1_o          = mst_p_data1_i;
    assign slv_p_dual_writeback_o = mst_p_dual_writeback_i;
    assign slv_p_rd_o             = mst_p_rd_i;
    assign slv_p_error_o          = mst_p_error_i;
    assign slv_p_id_o             = mst_p_id_i[IdWidth-1:0];
`endif

`ifndef SYNTHESIS
    rsp_idx_range: assert property (
        @(posedge clk_i) disable iff (rst_i)
        mst_p_valid_i |-> idx_ok
    ) else $warning("response index out of range, response sunk");

    locked_req_held: assert property (
        @(posedge clk_i) disable iff (rst_i)
        lock |-> slv_q_valid_i[lock_idx]
    ) else $error("locked requester dropped valid");
`endif

endmodule

// File: tb/tb_acc_rr_arbiter.sv
// Directed bench for acc_rr_arbiter: Q arbitration, locking, P routing and reset.
// A second instance with NumReq=3 exercises the sunk out-of-range response.
module tb_acc_rr_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] q_addr [4];
    logic [31:0] q_op   [4];
    logic [31:0] q_a    [4];
    logic [31:0] q_b    [4];
    logic [31:0] q_c    [4];
    logic [3:0]  q_id   [4];
    logic [3:0]  q_valid;
    logic [3:0]  q_ready;
    logic [31:0] p_d0, p_d1;
    logic        p_dw, p_err;
    logic [4:0]  p_rd;
    logic [3:0]  p_id;
    logic [3:0]  p_valid;
    logic [3:0]  p_ready;
    logic [31:0] m_addr, m_op, m_a, m_b, m_c;
    logic [5:0]  m_qid;
    logic        m_qvalid, m_qready;
    logic [31:0] m_d0, m_d1;
    logic        m_dw, m_err;
    logic [4:0]  m_rd;
    logic [5:0]  m_pid;
    logic        m_pvalid, m_pready;

    acc_rr_arbiter #(.NumReq(4)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .slv_q_addr_i(q_addr), .slv_q_data_op_i(q_op),
        .slv_q_data_arga_i(q_a), .slv_q_data_argb_i(q_b),
        .slv_q_data_argc_i(q_c), .slv_q_id_i(q_id),
        .slv_q_valid_i(q_valid), .slv_q_ready_o(q_ready),
        .slv_p_data0_o(p_d0), .slv_p_data1_o(p_d1),
        .slv_p_dual_writeback_o(p_dw), .slv_p_rd_o(p_rd),
        .slv_p_error_o(p_err), .slv_p_id_o(p_id),
        .slv_p_valid_o(p_valid), .slv_p_ready_i(p_ready),
        .mst_q_addr_o(m_addr), .mst_q_data_op_o(m_op),
        .mst_q_data_arga_o(m_a), .mst_q_data_argb_o(m_b),
        .mst_q_data_argc_o(m_c), .mst_q_id_o(m_qid),
        .mst_q_valid_o(m_qvalid), .mst_q_ready_i(m_qready),
        .mst_p_data0_i(m_d0), .mst_p_data1_i(m_d1),
        .mst_p_dual_writeback_i(m_dw), .mst_p_rd_i(m_rd),
        .mst_p_error_i(m_err), .mst_p_id_i(m_pid),
        .mst_p_valid_i(m_pvalid), .mst_p_ready_o(m_pready)
    );

    logic [31:0] t_addr [3];
    logic [31:0] t_op   [3];
    logic [31:0] t_a    [3];
    logic [31:0] t_b    [3];
    logic [31:0] t_c    [3];
    logic [3:0]  t_id   [3];
    logic [2:0]  t_qvalid, t_qready;
    logic [31:0] t_pd0, t_pd1;
    logic        t_pdw, t_perr;
    logic [4:0]  t_prd;
    logic [3:0]  t_pid;
    logic [2:0]  t_pvalid, t_pready;
    logic [31:0] t_maddr, t_mop, t_ma, t_mb, t_mc;
    logic [5:0]  t_mqid;
    logic        t_mqvalid;
    logic [5:0]  t_mpid;
    logic        t_mpvalid, t_mpready;

    acc_rr_arbiter #(.NumReq(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst),
        .slv_q_addr_i(t_addr), .slv_q_data_op_i(t_op),
        .slv_q_data_arga_i(t_a), .slv_q_data_argb_i(t_b),
        .slv_q_data_argc_i(t_c), .slv_q_id_i(t_id),
        .slv_q_valid_i(t_qvalid), .slv_q_ready_o(t_qready),
        .slv_p_data0_o(t_pd0), .slv_p_data1_o(t_pd1),
        .slv_p_dual_writeback_o(t_pdw), .slv_p_rd_o(t_prd),
        .slv_p_error_o(t_perr), .slv_p_id_o(t_pid),
        .slv_p_valid_o(t_pvalid), .slv_p_ready_i(t_pready),
        .mst_q_addr_o(t_maddr), .mst_q_data_op_o(t_mop),
        .mst_q_data_arga_o(t_ma), .mst_q_data_argb_o(t_mb),
        .mst_q_data_argc_o(t_mc), .mst_q_id_o(t_mqid),
        .mst_q_valid_o(t_mqvalid), .mst_q_ready_i(1'b1),
        .mst_p_data0_i(32'h0), .mst_p_data1_i(32'h0),
        .mst_p_dual_writeback_i(1'b0), .mst_p_rd_i(5'd0),
        .mst_p_error_i(1'b0), .mst_p_id_i(t_mpid),
        .mst_p_valid_i(t_mpvalid), .mst_p_ready_o(t_mpready)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_g;

    initial begin
        for (int i = 0; i < 4; i++) begin
            q_addr[i] = 32'h1000 + i;
            q_op[i]   = 32'hA0 + i;
            q_a[i]    = 32'hB0 + i;
            q_b[i]    = 32'hC0 + i;
            q_c[i]    = 32'hD0 + i;
            q_id[i]   = 4'h8 + 4'(i);
        end
        for (int i = 0; i < 3; i++) begin
            t_addr[i] = '0; t_op[i] = '0; t_a[i] = '0;
            t_b[i] = '0; t_c[i] = '0; t_id[i] = '0;
        end
        t_qvalid = '0; t_pready = '0; t_mpid = '0; t_mpvalid = 1'b0;
        rst = 1'b1; q_valid = 4'hf; m_qready = 1'b1;
        m_d0 = 32'h0; m_d1 = 32'h0; m_dw = 1'b0; m_rd = 5'd0;
        m_err = 1'b0; m_pid = {2'd1, 4'h2}; m_pvalid = 1'b1;
        p_ready = 4'hf;

        // Outputs gated during reset
        repeat (2) tick();
        chk("rst_qvalid", m_qvalid, 0);
        chk("rst_qready", q_ready, 0);
        chk("rst_pvalid", p_valid, 0);
        chk("rst_pready", m_pready, 0);
        rst = 1'b0; q_valid = '0; m_pvalid = 1'b0;
        tick();

        // Requesters 0 and 2
        q_valid = 4'b0101; #1;
        chk("t1_ready0", q_ready, 4'b0001);
        chk("t1_id0", m_qid, 6'h08);
        tick();
        chk("t1_ready2", q_ready, 4'b0100);
        chk("t1_id2", m_qid, 6'h2A);
        chk("t1_addr2", m_addr, 32'h1002);
        tick();
        q_valid = '0;
        rst = 1'b1; tick(); rst = 1'b0;

        // All valid, full rotation
        q_valid = 4'hf;
        for (int k = 0; k < 5; k++) begin
            #1;
            exp_g = 4'b0001 << (k % 4);
            chk("t2_grant", q_ready, exp_g);
            tick();
        end

        // Lock across back-pressure (rr_ptr = 1)
        q_valid = 4'b0010; m_qready = 1'b0; #1;
        chk("t3_valid", m_qvalid, 1);
        chk("t3_id1", m_qid, 6'h19);
        tick();
        q_valid = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_hold_id", m_qid, 6'h19);
            chk("t3_hold_op", m_op, 32'hA1);
            chk("t3_noready", q_ready, 0);
            tick();
        end
        m_qready = 1'b1; #1;
        chk("t3_hs1", q_ready, 4'b0010);
        tick();
        q_valid = 4'b0001; #1;
        chk("t3_next0", q_ready, 4'b0001);
        chk("t3_arga0", m_a, 32'hB0);
        tick();
        q_valid = '0;

        // Response routing
        m_pid = {2'd3, 4'h5}; m_pvalid = 1'b1;
        m_d0 = 32'hDEAD0001; p_ready = 4'b0111; #1;
        chk("t4_pvalid", p_valid, 4'b1000);
        chk("t4_pid", p_id, 4'h5);
        chk("t4_pdata0", p_d0, 32'hDEAD0001);
        chk("t4_pready0", m_pready, 0);
        p_ready = 4'b1000; #1;
        chk("t4_pready1", m_pready, 1);
        m_pvalid = 1'b0; #1;
        chk("t4_pidle", p_valid, 0);

        // NumReq=3: index 3 sunk, index 2 routed
        t_mpid = {2'd3, 4'h9}; t_mpvalid = 1'b1; t_pready = 3'b000; #1;
        chk("t5_sink_ready", t_mpready, 1);
        chk("t5_sink_valid", t_pvalid, 0);
        t_mpid = {2'd2, 4'h9}; #1;
        chk("t5_idx2_valid", t_pvalid, 3'b100);
        chk("t5_idx2_ready", t_mpready, 0);
        t_mpvalid = 1'b0;
        tick();

        // Reset while locked (rr_ptr = 1, lock on requester 2)
        q_valid = 4'b0100; m_qready = 1'b0; #1;
        chk("t6_id2", m_qid, 6'h2A);
        tick();
        rst = 1'b1; #1;
        chk("t6_rst_qvalid", m_qvalid, 0);
        tick();
        rst = 1'b0; q_valid = 4'hf; m_qready = 1'b1; #1;
        chk("t6_grant0", q_ready, 4'b0001);
        tick();
        q_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/acc_rr_arbiter.md
# acc_rr_arbiter

Round-robin arbiter that shares one accelerator request/response port among `NumReq` offloading requesters. It sits between several cores (or adapters) and a single accelerator `in` port.
- On the request channel (Q) it extends each request's ID with the requester index.
- On the response channel (P) it uses that index to route the response back and removes it from the ID.
- It holds the grant stable across back-pressure, as the valid/ready stability rules require.

## Interface
Parameters:
- `NumReq`, 4: number of requesters; legal range 2..16.
- `DataWidth`, 32: width of operands and results.
- `AddrWidth`, 32: width of the Q address.
- `IdWidth`, 4: requester-side ID width.
- `IdxWidth`, derived as `$clog2(NumReq)`: requester index width.
- Accelerator-side ID width is `IdWidth+IdxWidth`. The index occupies the MSBs: `mst_q_id = {idx, slv_q_id}`.

Ports (`slv_*` signals are arrays indexed `[NumReq]`):
- `clk_i` in 1: clock; everything is on the rising edge.
- `rst_i` in 1: reset, synchronous and active-high.
- `slv_q_addr_i` in `AddrWidth`: request address, per requester.
- `slv_q_data_op_i` in 32: instruction word.
- `slv_q_data_arga_i`, `slv_q_data_argb_i`, `slv_q_data_argc_i` in `DataWidth`: operands.
- `slv_q_id_i` in `IdWidth`: request ID.
- `slv_q_valid_i` in 1, `slv_q_ready_o` out 1: request handshake.
- `slv_p_data0_o`, `slv_p_data1_o` out `DataWidth`: results, broadcast to all requesters.
- `slv_p_dual_writeback_o` out 1, `slv_p_rd_o` out 5, `slv_p_error_o` out 1: response attributes, broadcast.
- `slv_p_id_o` out `IdWidth`: response ID with the index stripped, broadcast.
- `slv_p_valid_o` out 1 (per requester), `slv_p_ready_i` in 1: response handshake.
- `mst_q_addr_o`, `mst_q_data_op_o`, `mst_q_data_arga_o`, `mst_q_data_argb_o`, `mst_q_data_argc_o` out: the granted request's fields, same widths as the requester side.
- `mst_q_id_o` out `IdWidth+IdxWidth`: extended request ID.
- `mst_q_valid_o` out 1, `mst_q_ready_i` in 1: accelerator-side request handshake.
- `mst_p_data0_i`, `mst_p_data1_i` in `DataWidth`: accelerator results.
- `mst_p_dual_writeback_i` in 1, `mst_p_rd_i` in 5, `mst_p_error_i` in 1: response attributes.
- `mst_p_id_i` in `IdWidth+IdxWidth`: extended response ID.
- `mst_p_valid_i` in 1, `mst_p_ready_o` out 1: accelerator-side response handshake.

## Operation
State:
- `rr_ptr` [`IdxWidth`]: round-robin pointer.
- `lock` [1]: set while a presented request is waiting for ready.
- `lock_idx` [`IdxWidth`]: the requester held by the lock.
- Response register, when the configuration option is enabled.

Q arbitration:
- Grant when unlocked: the first requester with `slv_q_valid_i` set, searching from `rr_ptr` upward and wrapping modulo `NumReq`.
- Grant when locked: `lock_idx`.
- `mst_q_valid_o = |slv_q_valid_i`. All `mst_q_*` fields are muxed from the granted requester.
- `slv_q_ready_o[g] = mst_q_ready_i` for the granted requester `g`; 0 for all others.
- No request is ever dropped or duplicated.

State updates:
- `mst_q_valid_o && !mst_q_ready_i`: `lock` ← 1, `lock_idx` ← g. This keeps the fields stable until the handshake.
- Handshake (`mst_q_valid_o && mst_q_ready_i`): `lock` ← 0, `rr_ptr` ← (g+1) mod `NumReq`.
- With no valid request, state holds.

P routing:
- `idx = mst_p_id_i[IdWidth+IdxWidth-1:IdWidth]`.
- `slv_p_valid_o[idx] = mst_p_valid_i`; 0 for all others.
- `mst_p_ready_o = slv_p_ready_i[idx]`.
- `idx >= NumReq` (non-power-of-two `NumReq`): the response is sunk. `mst_p_ready_o` = 1, no `slv_p_valid_o` is raised, and a simulation-only assertion fires.

## Timing
- Q path has zero latency, combinational from inputs and state.
- `mst_q_valid_o` never depends on `mst_q_ready_i`.
- P path has zero latency without the configuration option and one cycle with it.
- Q and P are independent; handshakes on both in the same cycle are legal.
- Reset values: `rr_ptr` = 0, `lock` = 0, response register empty.
- While `rst_i` is high, `mst_q_valid_o`, `slv_q_ready_o`, `slv_p_valid_o` and `mst_p_ready_o` are all 0.
- Reset asserted mid-transfer aborts the pending grant; requesters must re-present after reset.
- A requester that drops valid while locked is a protocol violation; behaviour is undefined and is flagged by an assertion.

## Configuration
- `ACC_ARB_RSP_REG_EN` defined: a one-entry, full-throughput pipeline register on the P path.
  - Latency is one cycle.
  - `mst_p_ready_o = !full || slv_p_ready_i[idx_reg]`, where `idx_reg` is the index of the registered response.
  - A new response is accepted in the same cycle the held one drains.
- `ACC_ARB_RSP_REG_EN` undefined: the P path is purely combinational, as described in Operation.

## Test plan
- Requesters 0 and 2 valid at once, `rr_ptr` = 0, `mst_q_ready_i` = 1 → requester 0 is granted with `mst_q_id_o = {2'd0, id}`; requester 2 is granted the next cycle.
- All 4 requesters valid continuously, ready always 1 → grants in order 0,1,2,3,0, one per cycle.
- Requester 1 granted, `mst_q_ready_i` held 0 for 3 cycles while requester 0 also becomes valid → grant stays 1 with fields stable; requester 0 is granted after the handshake.
- Response with `mst_p_id_i = {2'd3, 4'h5}` → `slv_p_valid_o[3]` = 1, `slv_p_id_o` = 5; `slv_p_ready_i[3]` held 0 → `mst_p_ready_o` = 0.
- With `NumReq` = 3, response index 3 → response is sunk with `mst_p_ready_o` = 1, and no requester sees valid.
- `rst_i` pulsed while locked → `lock` = 0 and `rr_ptr` = 0 after reset; with `ACC_ARB_RSP_REG_EN`, the response register is empty.
